// File: rtl/snake_board.sv
// Snake playfield: per-cell age counters, head/direction/length state, apple handshake
// and per-cell red/green pixel map. Advances one game step per tick.
module snake_board #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int START_ROW = 3,
  parameter int START_COL = 3,
  parameter int WRAP      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [1:0]                   dir_in,
  input  logic                         apple_load,
  input  logic [$clog2(ROWS)-1:0]      apple_row,
  input  logic [$clog2(COLS)-1:0]      apple_col,
  output logic                         apple_req,
  output logic [ROWS*COLS-1:0]         red_px,
  output logic [ROWS*COLS-1:0]         green_px,
  output logic [$clog2(ROWS)-1:0]      head_row,
  output logic [$clog2(COLS)-1:0]      head_col,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         ate,
  output logic                         game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic {
    PLAYING,
    OVER
  } game_t;

  game_t           state, state_next;
  dir_t            dir, dir_eff;
  logic [LW-1:0]   age      [N];
  logic [LW-1:0]   age_next [N];
  logic            apple_valid, apple_valid_next;
  logic [RW-1:0]   apple_r;
  logic [CW-1:0]   apple_c;
  logic [RW-1:0]   tgt_row;
  logic [CW-1:0]   tgt_col;
  logic [IW-1:0]   tgt_idx, ld_idx, head_idx, apple_idx;
  logic [LW-1:0]   tgt_age, length_next;
  logic            off_board, step, crash, eat, grow, move_ok;
  logic            ld_in_range, ld_accept;

  assign step      = tick && (state == PLAYING);
  assign game_over = (state == OVER);
  assign apple_req = !apple_valid;
  assign tgt_idx   = IW'(tgt_row * COLS + tgt_col);
  assign ld_idx    = IW'(apple_row * COLS + apple_col);
  assign head_idx  = IW'(head_row * COLS + head_col);
  assign apple_idx = IW'(apple_r * COLS + apple_c);

  // A reversal request is dropped; otherwise the sampled direction drives this step.
  always_comb begin
    dir_eff   = dir_t'(dir_in);
    if (dir_in == (dir ^ 2'b10)) dir_eff = dir;
    tgt_row   = head_row;
    tgt_col   = head_col;
    off_board = 1'b0;
    case (dir_eff)
      DIR_RIGHT: begin
        if (head_col == CW'(COLS - 1)) begin
          off_board = 1'b1;
          tgt_col   = '0;
        end else begin
          tgt_col = head_col + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (head_row == RW'(ROWS - 1)) begin
          off_board = 1'b1;
          tgt_row   = '0;
        end else begin
          tgt_row = head_row + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (head_col == '0) begin
          off_board = 1'b1;
          tgt_col   = CW'(COLS - 1);
        end else begin
          tgt_col = head_col - 1'b1;
        end
      end
      default: begin
        if (head_row == '0) begin
          off_board = 1'b1;
          tgt_row   = RW'(ROWS - 1);
        end else begin
          tgt_row = head_row - 1'b1;
        end
      end
    endcase
  end

  // Age 1 marks the tail, which vacates during this step, so only ages above 1 collide.
  always_comb begin
    tgt_age = age[tgt_idx];
    crash   = (off_board && (WRAP == 0)) || (tgt_age > LW'(1));
    eat     = apple_valid && (tgt_row == apple_r) && (tgt_col == apple_c);
    grow    = eat && (length != LW'(MAX_LEN));
    move_ok = step && !crash;
  end

  always_comb begin
    length_next = length;
    for (int i = 0; i < N; i++) age_next[i] = age[i];
    if (move_ok) begin
      for (int i = 0; i < N; i++) begin
        if (!grow && (age[i] != '0)) age_next[i] = age[i] - 1'b1;
      end
      age_next[tgt_idx] = grow ? length + 1'b1 : length;
      if (grow) length_next = length + 1'b1;
    end
  end

  // Apple loads are judged against the board as it will look after this cycle's step.
  always_comb begin
    ld_in_range      = (32'(apple_row) < ROWS) && (32'(apple_col) < COLS);
    ld_accept        = apple_load && !apple_valid && ld_in_range && (age_next[ld_idx] == '0);
    apple_valid_next = apple_valid;
    if (move_ok && eat) apple_valid_next = 1'b0;
    else if (ld_accept) apple_valid_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= PLAYING;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAYING: if (step && crash) state_next = OVER;
      default: state_next = OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          age[r*COLS + c] <= (r == START_ROW && c <= START_COL && c > START_COL - INIT_LEN)
                             ? LW'(INIT_LEN - START_COL + c) : '0;
        end
      end
      head_row    <= RW'(START_ROW);
      head_col    <= CW'(START_COL);
      dir         <= DIR_RIGHT;
      length      <= LW'(INIT_LEN);
      apple_valid <= 1'b0;
      apple_r     <= '0;
      apple_c     <= '0;
      ate         <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) age[i] <= age_next[i];
      if (step) dir <= dir_eff;
      if (move_ok) begin
        head_row <= tgt_row;
        head_col <= tgt_col;
      end
      length      <= length_next;
      apple_valid <= apple_valid_next;
      if (ld_accept) begin
        apple_r <= apple_row;
        apple_c <= apple_col;
      end
      ate <= move_ok && eat;
    end
  end

  always_comb begin
    red_px   = '0;
    green_px = '0;
    for (int i = 0; i < N; i++) begin
      if (age[i] != '0) begin
        green_px[i] = 1'b1;
        red_px[i]   = (IW'(i) != head_idx);
      end else if (apple_valid && (IW'(i) == apple_idx)) begin
        red_px[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_board.sv
// Bench for snake_board: a wall-ending board and a wrapping short-snake board share stimulus
// and are compared against a coordinate-list model of the game.
module tb_snake_board;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic        clk, reset, tick, apple_load;
  logic [1:0]  dir_in;
  logic [2:0]  apple_row, apple_col;
  logic        req0, ate0, go0, req1, ate1, go1;
  logic [63:0] red0, green0, red1, green1;
  logic [2:0]  hr0, hc0, hr1, hc1;
  logic [4:0]  len0;
  logic [2:0]  len1;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: body as a head-first list of coordinates per board.
  int m_len[2], m_maxlen[2], m_wrap[2], m_dir[2], m_ar[2], m_ac[2];
  bit m_over[2], m_apple_v[2], m_ate[2];
  int br[2][64], bc[2][64];

  snake_board u_nowrap (
    .clk(clk), .reset(reset), .tick(tick), .dir_in(dir_in), .apple_load(apple_load),
    .apple_row(apple_row), .apple_col(apple_col), .apple_req(req0), .red_px(red0),
    .green_px(green0), .head_row(hr0), .head_col(hc0), .length(len0), .ate(ate0),
    .game_over(go0)
  );

  snake_board #(.MAX_LEN(5), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .tick(tick), .dir_in(dir_in), .apple_load(apple_load),
    .apple_row(apple_row), .apple_col(apple_col), .apple_req(req1), .red_px(red1),
    .green_px(green1), .head_row(hr1), .head_col(hc1), .length(len1), .ate(ate1),
    .game_over(go1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int body_index(input int m, input int r, input int c);
    for (int k = 0; k < m_len[m]; k++) if (br[m][k] == r && bc[m][k] == c) return k;
    return -1;
  endfunction

  function automatic logic [63:0] exp_pixels(input int m, input bit red);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < m_len[m]; k++) if (!red || k > 0) v[br[m][k]*COLS + bc[m][k]] = 1'b1;
    if (red && m_apple_v[m]) v[m_ar[m]*COLS + m_ac[m]] = 1'b1;
    return v;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      m_len[m] = 3; m_dir[m] = 0; m_over[m] = 0; m_apple_v[m] = 0; m_ate[m] = 0;
      for (int k = 0; k < 3; k++) begin
        br[m][k] = 3;
        bc[m][k] = 3 - k;
      end
    end
  endtask

  task automatic modelStep(input int m, input bit t, input int d, input bit ld,
                           input int lr, input int lc);
    int eff, nr, nc, k;
    bit req_old, off, eat, grow;
    req_old  = !m_apple_v[m];
    m_ate[m] = 0;
    if (t && !m_over[m]) begin
      eff = (d == (m_dir[m] ^ 2)) ? m_dir[m] : d;
      m_dir[m] = eff;
      nr = br[m][0] + (eff == 1 ? 1 : 0) - (eff == 3 ? 1 : 0);
      nc = bc[m][0] + (eff == 0 ? 1 : 0) - (eff == 2 ? 1 : 0);
      off = (nr < 0) || (nr >= ROWS) || (nc < 0) || (nc >= COLS);
      if (off && m_wrap[m] == 0) begin
        m_over[m] = 1;
      end else begin
        nr = (nr + ROWS) % ROWS;
        nc = (nc + COLS) % COLS;
        k  = body_index(m, nr, nc);
        if (k >= 0 && k < m_len[m] - 1) begin
          m_over[m] = 1;
        end else begin
          eat  = m_apple_v[m] && nr == m_ar[m] && nc == m_ac[m];
          grow = eat && m_len[m] < m_maxlen[m];
          if (grow) m_len[m]++;
          for (int j = m_len[m] - 1; j > 0; j--) begin
            br[m][j] = br[m][j-1];
            bc[m][j] = bc[m][j-1];
          end
          br[m][0] = nr;
          bc[m][0] = nc;
          if (eat) begin
            m_apple_v[m] = 0;
            m_ate[m]     = 1;
          end
        end
      end
    end
    if (ld && req_old && lr < ROWS && lc < COLS && body_index(m, lr, lc) < 0) begin
      m_apple_v[m] = 1;
      m_ar[m] = lr;
      m_ac[m] = lc;
    end
  endtask

  task automatic checkDut(input int m, input logic [63:0] red, input logic [63:0] green,
                          input logic [2:0] hr, input logic [2:0] hc, input logic [4:0] len,
                          input logic at, input logic go, input logic req);
    checkOutput($sformatf("dut%0d red_px", m), red, exp_pixels(m, 1'b1));
    checkOutput($sformatf("dut%0d green_px", m), green, exp_pixels(m, 1'b0));
    checkOutput($sformatf("dut%0d head_row", m), hr, br[m][0]);
    checkOutput($sformatf("dut%0d head_col", m), hc, bc[m][0]);
    checkOutput($sformatf("dut%0d length", m), len, m_len[m]);
    checkOutput($sformatf("dut%0d ate", m), at, m_ate[m]);
    checkOutput($sformatf("dut%0d game_over", m), go, m_over[m]);
    checkOutput($sformatf("dut%0d apple_req", m), req, !m_apple_v[m]);
  endtask

  // Inputs change just after a falling edge; outputs are compared at the next falling edge.
  task automatic applyStimulus(input bit rst, input bit t, input int d, input bit ld,
                               input int lr, input int lc);
    reset = rst; tick = t; dir_in = 2'(d); apple_load = ld;
    apple_row = 3'(lr); apple_col = 3'(lc);
    @(posedge clk);
    if (rst) modelReset();
    else for (int m = 0; m < 2; m++) modelStep(m, t, d, ld, lr, lc);
    @(negedge clk);
    checkDut(0, red0, green0, hr0, hc0, len0, ate0, go0, req0);
    checkDut(1, red1, green1, hr1, hc1, {2'b00, len1}, ate1, go1, req1);
  endtask

  initial begin
    bit r, t, ld;
    m_maxlen[0] = 16; m_wrap[0] = 0;
    m_maxlen[1] = 5;  m_wrap[1] = 1;
    reset = 1'b1; tick = 1'b0; dir_in = 2'b00; apple_load = 1'b0;
    apple_row = '0; apple_col = '0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst head green", green0[27], 1'b1);
    checkOutput("rst head red", red0[27], 1'b0);
    checkOutput("rst cell26 orange", {red0[26], green0[26]}, 2'b11);
    checkOutput("rst cell25 orange", {red0[25], green0[25]}, 2'b11);
    checkOutput("rst apple_req", req0, 1'b1);
    checkOutput("rst length", len0, 3);

    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("move head_col", hc0, 5);
    checkOutput("move cell25 off", green0[25], 1'b0);
    checkOutput("move cell26 off", green0[26], 1'b0);
    checkOutput("move length", len0, 3);
    applyStimulus(0, 1, 2, 0, 0, 0);
    checkOutput("reverse ignored", hc0, 6);

    applyStimulus(0, 0, 0, 1, 3, 5);
    checkOutput("body load rejected", req0, 1'b1);
    applyStimulus(0, 0, 0, 1, 3, 7);
    checkOutput("apple accepted", req0, 1'b0);
    checkOutput("apple red", {red0[31], green0[31]}, 2'b10);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("eat ate", ate0, 1'b1);
    checkOutput("eat length", len0, 4);
    checkOutput("eat apple_req", req0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ate one cycle", ate0, 1'b0);
    checkOutput("tail still lit", green0[28], 1'b1);

    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("wall game_over", go0, 1'b1);
    checkOutput("wall head frozen", hc0, 7);
    checkOutput("wrap head_col", hc1, 0);
    checkOutput("wrap no game_over", go1, 1'b0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("over tick ignored row", hr0, 3);
    checkOutput("over length frozen", len0, 4);

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 4);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 2, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 0, 0);
    checkOutput("enter tail legal", go0, 1'b0);
    checkOutput("enter tail head", {hr0, hc0}, {3'd3, 3'd3});
    applyStimulus(0, 0, 0, 1, 2, 3);
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 2, 0, 0, 0);
    checkOutput("age2 collision", go0, 1'b1);
    checkOutput("age2 length", len0, 5);
    checkOutput("age2 head frozen", {hr0, hc0}, {3'd3, 3'd4});

    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 59) == 0) || (m_over[0] && m_over[1]);
      t  = $urandom_range(0, 1) == 1;
      ld = $urandom_range(0, 2) == 0;
      applyStimulus(r, t, $urandom_range(0, 3), ld, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
